uart_la: RTL
============

# uart_la

UART-controlled 8-bit logic analyzer core: the receiving end of the host command stream (select, trigger mask, trigger compare, pretrigger). It sits inside `system` next to a `uart` instance, parses the four configuration bytes from it, and captures a selected probe byte into an on-chip ring buffer around a trigger event. It then streams the captured buffer back through the same UART transmitter.

## Interface
Parameters:
- `addr_width`, 9: buffer depth = 2^addr_width samples; legal range 8..12.

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `probe` in 64: eight 8-bit probe bytes; byte n is `probe[8n+7:8n]`.
- `rx_data` in 8: received byte from `uart`.
- `rx_avail` in 1: `rx_data` is valid; held until acked.
- `rx_ack` out 1: one-cycle pulse consuming `rx_data`.
- `tx_data` out 8: byte to transmit.
- `tx_wr` out 1: one-cycle write strobe to `uart`.
- `tx_busy` in 1: the UART transmitter is busy.
- `armed` out 1: high in ARM and WAIT_TRIG.
- `triggered` out 1: high in POST and DUMP.

## Operation
- States: CMD_SEL, CMD_MASK, CMD_CMP, CMD_PRE, ARM, WAIT_TRIG, POST, DUMP.
- CMD_*: on `rx_avail && !rx_ack`, latch the byte, pulse `rx_ack`, and advance.
  - `sel` = `rx_data[2:0]`; upper bits are ignored.
  - CMD_PRE stores `pre` and enters ARM with `wp`=0.
- Sample: `s = probe[8*sel +: 8]`, registered one cycle, then written to `buf[wp]` every cycle in ARM/WAIT_TRIG/POST; `wp` increments modulo depth.
- `pre_cnt = pre << (addr_width-8)`: number of samples retained before the trigger.
- ARM: write `pre_cnt` samples, then go to WAIT_TRIG. If `pre_cnt`=0, go to WAIT_TRIG immediately.
- WAIT_TRIG: keep writing (ring, wraps freely).
  - Trigger condition: `(s & mask) == (cmp & mask)`, evaluated on the sample being written in that cycle.
  - On a hit: `trig_addr <= wp`, then POST. The trigger sample counts as the first post sample.
  - `mask`=0 triggers on the first WAIT_TRIG cycle.
- POST: write until exactly `depth - pre_cnt` samples, counting the trigger sample, have been written. Then DUMP with `rp = trig_addr - pre_cnt` (mod depth).
- DUMP: send `depth` bytes, oldest first, `rp` incrementing with wrap.
  - Per byte: wait `!tx_busy`, read the RAM (1-cycle latency), drive `tx_data`, pulse `tx_wr` for one cycle.
  - Ignore `tx_busy` for the cycle after `tx_wr`.
  - After the last byte, return to CMD_SEL. The configuration registers keep their values.
- In ARM/WAIT_TRIG/POST/DUMP, received bytes are acked and discarded; they cause no state change.
- No abort path other than `reset`.

## Timing
- Reset (synchronous, takes effect on the next `clk` edge, including mid-capture or mid-dump):
  - Outputs: `rx_ack`=0, `tx_wr`=0, `tx_data`=0x00, `armed`=0, `triggered`=0.
  - Internal: state=CMD_SEL; `sel`/`mask`/`cmp`/`pre`=0; `wp`/`rp`/counters=0.
  - A byte in flight in the UART is not flushed; the block only drives `tx_wr`.
- `rx_ack`: asserted the cycle after `rx_avail` is seen, never two consecutive cycles.
- Probe-to-buffer latency: 2 cycles (probe register, then RAM write). A trigger on probe value P at cycle t is recorded at cycle t+1.
- `tx_wr` to the next `tx_wr` is at least 3 cycles, even if `tx_busy` stays 0.
- Boundaries:
  - `pre`=0xFF with addr_width 8: `pre_cnt`=255, POST writes 1 sample.
  - `pre_cnt` can never equal depth.
  - The `rp` computation wraps modulo depth.

## Structure
- Package `uart_la_pkg`: state enum, `SEL_W`=3, `PROBE_BYTES`=8, command byte order constants.
- Sub-module `la_ram`: simple dual-port RAM, one write port and one registered read port, width 8, depth 2^addr_width, inferable as block RAM.
- Remaining logic (FSM, counters, trigger compare, UART handshake) stays in `uart_la`.

## Test plan
- Config parse: send 00, FF, 80, 00 → four single-cycle `rx_ack` pulses; `armed` rises after the 4th byte.
- Pretrigger window (addr_width=9): counter on probe byte 0, send 00, FF, 80, 40 (`pre_cnt`=128) → 512 bytes dumped, bytes are consecutive, byte index 128 equals 0x80.
- Select/mask: sel=3, mask=0x0F, cmp=0x05, drive byte 3 = 0xA5 at cycle 1000 → trigger on the first A5 (upper nibble ignored); other probe bytes have no effect.
- Immediate trigger: mask=0x00, pre=0 → first dumped byte is the sample registered on the first WAIT_TRIG cycle; exactly 512 `tx_wr` pulses.
- Backpressure: hold `tx_busy`=1 for 50 cycles mid-dump → no `tx_wr` while busy; no byte lost or duplicated; then back in CMD_SEL.
- Reset mid-operation: assert `reset` during POST, and again after 10 bytes of DUMP → all outputs 0 the next cycle; a new 4-byte config works normally.

Source files
------------

// File: rtl/uart_la_pkg.sv
// Shared definitions for the UART-controlled logic analyzer.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package uart_la_pkg;

    // Top-level controller states, in command/capture/dump order.
    typedef enum logic [2:0] {
        CMD_SEL,
        CMD_MASK,
        CMD_CMP,
        CMD_PRE,
        ARM,
        WAIT_TRIG,
        POST,
        DUMP
    } state_t;

    // Per-byte handshake inside DUMP: wait for the transmitter, let the RAM
    // read land, then hold off one cycle while the UART raises tx_busy.
    typedef enum logic [1:0] {
        DP_WAIT,
        DP_LOAD,
        DP_HOLD
    } dump_phase_t;

    localparam int SEL_W       = 3;
    localparam int PROBE_BYTES = 8;

    // Order of the configuration bytes in the host command stream.
    localparam int CMD_IDX_SEL  = 0;
    localparam int CMD_IDX_MASK = 1;
    localparam int CMD_IDX_CMP  = 2;
    localparam int CMD_IDX_PRE  = 3;
    localparam int CMD_BYTES    = 4;

    // Masked trigger compare; a zero mask always hits.
    function automatic logic trig_hit(input logic [7:0] s,
                                      input logic [7:0] mask,
                                      input logic [7:0] cmp);
        return ((s & mask) == (cmp & mask));
    endfunction

endpackage

// File: rtl/la_ram.sv
// Capture buffer: simple dual-port RAM, one write port, one registered read port.
// Latency: write lands on the clock edge; read data valid one cycle after re.
// Backpressure: none; both ports accept an access every cycle.
//
// Ports:
//   clk              clock
//   we/wr_addr/wr_data  write port
//   re/rd_addr       read request; rd_data updates only when re is high
//   rd_data          registered read data
module la_ram #(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic                  re,
    input  logic [addr_width-1:0] rd_addr,
    output logic [7:0]            rd_data
);

    logic [7:0] mem [0:(1 << addr_width) - 1];

    // No reset on the array or read register so the block maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_la.sv
// 8-bit logic analyzer: parses sel/mask/cmp/pre from the UART, captures a probe byte around a trigger, dumps the buffer back.
// Latency: probe to buffer 2 cycles; rx_ack 1 cycle after rx_avail; tx_wr at most every 3 cycles.
// Backpressure: dump stalls while tx_busy is high; received bytes are always acked (discarded outside CMD_*).
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   probe[63:0]         eight probe bytes, byte n = probe[8n+7:8n]
//   rx_data/rx_avail    received byte from the UART, held until rx_ack
//   rx_ack              one-cycle consume pulse
//   tx_data/tx_wr       byte and one-cycle write strobe to the UART
//   tx_busy             UART transmitter busy
//   armed               high in ARM and WAIT_TRIG
//   triggered           high in POST and DUMP
module uart_la
    import uart_la_pkg::*;
#(
    parameter int addr_width = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [8*PROBE_BYTES-1:0]    probe,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_avail,
    output logic                        rx_ack,
    output logic [7:0]                  tx_data,
    output logic                        tx_wr,
    input  logic                        tx_busy,
    output logic                        armed,
    output logic                        triggered
);

    localparam logic [addr_width:0] DEPTH_V = {1'b1, {addr_width{1'b0}}};
    localparam logic [addr_width:0] CNT_ONE = {{addr_width{1'b0}}, 1'b1};

    state_t                 state;
    state_t                 state_next;
    dump_phase_t            phase;

    // Configuration registers; they survive a completed dump.
    logic [SEL_W-1:0]       sel;
    logic [7:0]             mask;
    logic [7:0]             cmp;
    logic [7:0]             pre;

    logic [7:0]             s_reg;
    logic [addr_width-1:0]  wp;
    logic [addr_width-1:0]  rp;
    logic [addr_width-1:0]  trig_addr;
    // Shared counter: pre samples in ARM, post samples in POST, bytes in DUMP.
    logic [addr_width:0]    cnt;
    logic [addr_width:0]    cnt_inc;

    logic [addr_width-1:0]  pre_cnt;
    logic [addr_width:0]    post_total;
    logic [7:0]             ram_rd;

    logic                   rx_take;
    logic                   hit;
    logic                   arm_done;
    logic                   post_done;
    logic                   dump_last;
    logic                   we;
    logic                   re;

    // pre scales to the buffer depth: pre_cnt = pre << (addr_width-8).
    always_comb begin
        pre_cnt = '0;
        pre_cnt[addr_width-1 -: 8] = pre;
    end

    assign post_total = DEPTH_V - {1'b0, pre_cnt};
    assign cnt_inc    = cnt + 1'b1;

    assign rx_take   = rx_avail && !rx_ack;
    // s_reg is exactly the sample being written this cycle.
    assign hit       = trig_hit(s_reg, mask, cmp);
    assign arm_done  = (pre_cnt == '0) || (cnt_inc == {1'b0, pre_cnt});
    assign post_done = (cnt == post_total);
    assign dump_last = (phase == DP_HOLD) && (cnt == DEPTH_V);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CMD_SEL;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            CMD_SEL:   if (rx_take)   state_next = CMD_MASK;
            CMD_MASK:  if (rx_take)   state_next = CMD_CMP;
            CMD_CMP:   if (rx_take)   state_next = CMD_PRE;
            CMD_PRE:   if (rx_take)   state_next = ARM;
            ARM:       if (arm_done)  state_next = WAIT_TRIG;
            WAIT_TRIG: if (hit)       state_next = POST;
            POST:      if (post_done) state_next = DUMP;
            DUMP:      if (dump_last) state_next = CMD_SEL;
            default:                  state_next = CMD_SEL;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        we        = 1'b0;
        re        = 1'b0;
        armed     = 1'b0;
        triggered = 1'b0;
        case (state)
            ARM: begin
                armed = 1'b1;
                we    = (pre_cnt != '0);
            end
            WAIT_TRIG: begin
                armed = 1'b1;
                we    = 1'b1;
            end
            POST: begin
                triggered = 1'b1;
                // The cycle that sees the count complete writes nothing.
                we        = !post_done;
            end
            DUMP: begin
                triggered = 1'b1;
                re        = (phase == DP_WAIT) && !tx_busy;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: config latch, sample pipe, pointers, UART handshakes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ack    <= 1'b0;
            tx_wr     <= 1'b0;
            tx_data   <= 8'h00;
            sel       <= '0;
            mask      <= 8'h00;
            cmp       <= 8'h00;
            pre       <= 8'h00;
            s_reg     <= 8'h00;
            wp        <= '0;
            rp        <= '0;
            trig_addr <= '0;
            cnt       <= '0;
            phase     <= DP_WAIT;
        end else begin
            // Bytes are consumed in every state; only CMD_* keep them.
            rx_ack <= rx_take;
            tx_wr  <= 1'b0;
            s_reg  <= probe[{sel, 3'b000} +: 8];

            if (we) begin
                wp <= wp + 1'b1;
            end

            case (state)
                CMD_SEL:  if (rx_take) sel  <= rx_data[SEL_W-1:0];
                CMD_MASK: if (rx_take) mask <= rx_data;
                CMD_CMP:  if (rx_take) cmp  <= rx_data;
                CMD_PRE: begin
                    if (rx_take) begin
                        pre <= rx_data;
                        wp  <= '0;
                        cnt <= '0;
                    end
                end
                ARM: begin
                    cnt <= arm_done ? '0 : cnt_inc;
                end
                WAIT_TRIG: begin
                    if (hit) begin
                        // The trigger sample is the first post sample.
                        trig_addr <= wp;
                        cnt       <= CNT_ONE;
                    end
                end
                POST: begin
                    if (post_done) begin
                        cnt   <= '0;
                        rp    <= trig_addr - pre_cnt;
                        phase <= DP_WAIT;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DUMP: begin
                    case (phase)
                        DP_WAIT: begin
                            if (!tx_busy) begin
                                phase <= DP_LOAD;
                            end
                        end
                        DP_LOAD: begin
                            tx_data <= ram_rd;
                            tx_wr   <= 1'b1;
                            rp      <= rp + 1'b1;
                            cnt     <= cnt_inc;
                            phase   <= DP_HOLD;
                        end
                        DP_HOLD: begin
                            // tx_busy has not risen yet in the tx_wr cycle.
                            phase <= DP_WAIT;
                            if (cnt == DEPTH_V) begin
                                cnt <= '0;
                            end
                        end
                        default: phase <= DP_WAIT;
                    endcase
                end
                default: ;
            endcase
        end
    end

    la_ram #(
        .addr_width (addr_width)
    ) u_ram (
        .clk     (clk),
        .we      (we),
        .wr_addr (wp),
        .wr_data (s_reg),
        .re      (re),
        .rd_addr (rp),
        .rd_data (ram_rd)
    );

endmodule
